// File: rtl/fetchflare_fifo_pkg.sv
// Shared constants and helpers for the prefetch FIFO read-side stream adapter.
package fetchflare_fifo_pkg;

  localparam int FETCH_DW      = 160;
  localparam int OUT_DEPTH_DEF = 2;

  // Ceiling log2, never less than 1 so a pointer or counter is at least one bit wide.
  function automatic int log2_ceil(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/fifo_rd_stream_adapter_buf.sv
// stream_out_buf: small register ring buffer feeding the output stream.
// DEPTH need not be a power of two; pointers wrap explicitly at DEPTH-1.
module stream_out_buf
  import fetchflare_fifo_pkg::*;
#(
  parameter int Dw    = FETCH_DW,
  parameter int DEPTH = OUT_DEPTH_DEF,
  localparam int PW   = log2_ceil(DEPTH),
  localparam int CW   = log2_ceil(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [Dw-1:0] push_data_i,
  input  logic          pop_i,
  output logic [CW-1:0] count_o,
  output logic          valid_o,
  output logic [Dw-1:0] data_o
);

  logic [Dw-1:0] mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_ok;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign pop_ok  = pop_i & (count_q != '0);
  assign valid_o = (count_q != '0);
  assign count_o = count_q;
  assign data_o  = mem_q[head_q];

  // Next pointer/occupancy: simultaneous push and pop leaves count unchanged.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_i) tail_d = wrap_inc(tail_q);
    if (pop_ok) head_d = wrap_inc(head_q);
    case ({push_i, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; overflow is impossible by construction upstream.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      assert (!(push_i && !pop_ok && (count_q == CW'(DEPTH))));
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Data storage needs no reset: entries are only visible while count covers them.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[tail_q] <= push_data_i;
  end

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// fifo_rd_stream_adapter: turns a registered-output FIFO (dout one cycle after
// rd_en) into a valid/ready stream at one beat per cycle.
// Reads are only issued when the output buffer has room for every datum already
// buffered or in flight, so a returning read always has a slot.
// Optional build macro FIFO_STREAM_STATS_EN adds saturating beat/stall counters.
module fifo_rd_stream_adapter
  import fetchflare_fifo_pkg::*;
#(
  parameter int Dw        = FETCH_DW,
  parameter int OUT_DEPTH = OUT_DEPTH_DEF,
  parameter int CNTw      = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [Dw-1:0]   fifo_dout,
  input  logic            fifo_empty,
  output logic            fifo_rd_en,
  output logic            m_valid,
  output logic [Dw-1:0]   m_data,
  input  logic            m_ready
`ifdef FIFO_STREAM_STATS_EN
  ,
  output logic [CNTw-1:0] stat_beats,
  output logic [CNTw-1:0] stat_stalls
`endif
);

  localparam int CW = log2_ceil(OUT_DEPTH + 1);
  localparam int RW = CW + 1;
  localparam logic [RW-1:0] DEPTH_W = RW'(OUT_DEPTH);

  if ((OUT_DEPTH < 2) || (CNTw < 1)) begin : g_param_check
    $error("fifo_rd_stream_adapter: OUT_DEPTH must be >= 2 and CNTw >= 1");
  end

  logic [CW-1:0] buf_count;
  logic [RW-1:0] resv;
  logic          pop;
  logic          inflight_q;

  assign pop = m_valid & m_ready;

  // Slots claimed after this cycle: buffered + returning read - leaving beat.
  assign resv       = RW'(buf_count) + RW'(inflight_q) - RW'(pop);
  assign fifo_rd_en = ~fifo_empty & ~reset & (resv < DEPTH_W);

  // One read outstanding at most; its data lands in the buffer the next cycle.
  always_ff @(posedge clk) begin
    if (reset) inflight_q <= 1'b0;
    else       inflight_q <= fifo_rd_en;
  end

  stream_out_buf #(
    .Dw    (Dw),
    .DEPTH (OUT_DEPTH)
  ) u_out_buf (
    .clk_i       (clk),
    .rst_i       (reset),
    .push_i      (inflight_q),
    .push_data_i (fifo_dout),
    .pop_i       (pop),
    .count_o     (buf_count),
    .valid_o     (m_valid),
    .data_o      (m_data)
  );

`ifdef FIFO_STREAM_STATS_EN
  logic [CNTw-1:0] beats_q, beats_d;
  logic [CNTw-1:0] stalls_q, stalls_d;

  // Saturating increments so the counters stick at all-ones instead of wrapping.
  always_comb begin
    beats_d  = beats_q;
    stalls_d = stalls_q;
    if (pop && (beats_q != '1))                    beats_d  = beats_q + CNTw'(1);
    if (m_valid && !m_ready && (stalls_q != '1))   stalls_d = stalls_q + CNTw'(1);
  end

  // Statistic registers, cleared together with the datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      beats_q  <= '0;
      stalls_q <= '0;
    end else begin
      beats_q  <= beats_d;
      stalls_q <= stalls_d;
    end
  end

  assign stat_beats  = beats_q;
  assign stat_stalls = stalls_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Bench for fifo_rd_stream_adapter: a queue models the upstream FIFO (registered
// dout), and a scoreboard queue holds every word handed to the FIFO in order.
module tb_fifo_rd_stream_adapter;

  localparam int DW = 160;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] fifo_dout;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
`ifdef FIFO_STREAM_STATS_EN
  logic [31:0]   stat_beats;
  logic [31:0]   stat_stalls;
`endif

  always #5 clk = ~clk;

  fifo_rd_stream_adapter #(.Dw(DW), .OUT_DEPTH(2), .CNTw(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready)
`ifdef FIFO_STREAM_STATS_EN
    ,
    .stat_beats (stat_beats),
    .stat_stalls(stat_stalls)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] src_q[$];
  logic [DW-1:0] exp_q[$];

  logic          rd_s, mv_s;
  logic [DW-1:0] md_s;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_md;
  int            pops = 0;
  int            rd_cnt = 0;
  int            rd_err = 0;

  function automatic logic [DW-1:0] rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic load(input logic [DW-1:0] d);
    src_q.push_back(d);
    exp_q.push_back(d);
    fifo_empty = 1'b0;
  endtask

  // One clock: sample at negedge, scoreboard beats, then advance the FIFO model.
  task automatic step_cycle();
    logic [DW-1:0] e;
    @(negedge clk);
    rd_s = fifo_rd_en;
    mv_s = m_valid;
    md_s = m_data;
    if (rd_s && fifo_empty) begin
      rd_err++;
      errors++;
      $display("FAIL empty_read rd_en=1 while fifo_empty=1 at %0t", $time);
    end
    if (mv_s && m_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected got %h exp none", md_s);
      end else begin
        e = exp_q.pop_front();
        if (md_s !== e) begin
          errors++;
          $display("FAIL beat_data got %h exp %h", md_s, e);
        end
      end
      pops++;
    end
    if (prev_stall) begin
      checks++;
      if (!mv_s || (md_s !== prev_md)) begin
        errors++;
        $display("FAIL stall_hold got v=%0b d=%h exp v=1 d=%h", mv_s, md_s, prev_md);
      end
    end
    prev_stall = mv_s && !m_ready && !reset;
    prev_md    = md_s;
    if (rd_s) rd_cnt++;
    @(posedge clk);
    #1;
    if (reset) begin
      src_q.delete();
      exp_q.delete();
      prev_stall = 1'b0;
    end else if (rd_s && (src_q.size() != 0)) begin
      fifo_dout = src_q.pop_front();
    end
    fifo_empty = (src_q.size() == 0);
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    m_ready = 1'b0;
    load(rand_word());
    step_cycle();
    checks++;
    if (rd_s !== 1'b0) begin errors++; $display("FAIL reset_rd_forced got %0b exp 0", rd_s); end
    step_cycle();
    checks++;
    if (mv_s !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", mv_s); end
    reset = 1'b0;
    step_cycle();
    checks++;
    if ((mv_s !== 1'b0) || (rd_s !== 1'b0)) begin
      errors++;
      $display("FAIL post_reset_idle got v=%0b rd=%0b exp 0 0", mv_s, rd_s);
    end
  endtask

  task automatic test_basic();
    logic [5:0] er, ev;
    int p0;
    er = 6'b000111;
    ev = 6'b011100;
    p0 = pops;
    m_ready = 1'b1;
    load(160'hA);
    load(160'hB);
    load(160'hC);
    for (int i = 0; i < 6; i++) begin
      step_cycle();
      checks++;
      if ((rd_s !== er[i]) || (mv_s !== ev[i])) begin
        errors++;
        $display("FAIL basic_timing cyc%0d got rd=%0b v=%0b exp rd=%0b v=%0b", i, rd_s, mv_s, er[i], ev[i]);
      end
    end
    checks++;
    if (pops - p0 != 3) begin errors++; $display("FAIL basic_count got %0d exp 3", pops - p0); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] w0;
    int p0;
    m_ready = 1'b0;
    w0 = rand_word();
    load(w0);
    for (int i = 1; i < 8; i++) load(rand_word());
    rd_cnt = 0;
    for (int i = 0; i < 10; i++) step_cycle();
    checks++;
    if (rd_cnt != 2) begin errors++; $display("FAIL bp_reads got %0d exp 2", rd_cnt); end
    checks++;
    if (rd_s !== 1'b0) begin errors++; $display("FAIL bp_rd_low got %0b exp 0", rd_s); end
    checks++;
    if ((mv_s !== 1'b1) || (md_s !== w0)) begin
      errors++;
      $display("FAIL bp_word0 got v=%0b d=%h exp v=1 d=%h", mv_s, md_s, w0);
    end
    m_ready = 1'b1;
    p0 = pops;
    for (int i = 0; i < 8; i++) begin
      step_cycle();
      checks++;
      if (pops - p0 != i + 1) begin
        errors++;
        $display("FAIL bp_drain cyc%0d got %0d beats exp %0d", i, pops - p0, i + 1);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL bp_left got %0d exp 0", exp_q.size()); end
  endtask

  task automatic test_empty_bursts();
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      load(rand_word());
      for (int j = 0; j < 4; j++) begin
        step_cycle();
        checks++;
        if (mv_s !== (j == 2)) begin
          errors++;
          $display("FAIL burst_valid word%0d cyc%0d got %0b exp %0b", k, j, mv_s, (j == 2));
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    int p0;
    m_ready = 1'b1;
    load(160'h77);
    load(160'h88);
    step_cycle();
    checks++;
    if (rd_s !== 1'b1) begin errors++; $display("FAIL mid_rd got %0b exp 1", rd_s); end
    reset = 1'b1;
    step_cycle();
    checks++;
    if (rd_s !== 1'b0) begin errors++; $display("FAIL mid_rd_reset got %0b exp 0", rd_s); end
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step_cycle();
      checks++;
      if ((mv_s !== 1'b0) || (rd_s !== 1'b0)) begin
        errors++;
        $display("FAIL mid_flushed cyc%0d got v=%0b rd=%0b exp 0 0", i, mv_s, rd_s);
      end
    end
    p0 = pops;
    load(160'h55);
    for (int i = 0; i < 5; i++) step_cycle();
    checks++;
    if (pops - p0 != 1) begin errors++; $display("FAIL mid_single got %0d beats exp 1", pops - p0); end
  endtask

  task automatic test_random();
    int sent, p0, cyc;
    sent = 0;
    cyc  = 0;
    p0   = pops;
    rd_err = 0;
    while ((pops - p0 < 1000) && (cyc < 8000)) begin
      m_ready = 1'($urandom_range(0, 1));
      if ((sent < 1000) && ($urandom_range(0, 3) != 0)) begin
        load(rand_word());
        sent++;
      end
      step_cycle();
      cyc++;
    end
    checks++;
    if (pops - p0 != 1000) begin errors++; $display("FAIL rand_beats got %0d exp 1000", pops - p0); end
    checks++;
    if (rd_err != 0) begin errors++; $display("FAIL rand_empty_reads got %0d exp 0", rd_err); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rand_left got %0d exp 0", exp_q.size()); end
  endtask

`ifdef FIFO_STREAM_STATS_EN
  task automatic test_stats();
    int p0, cyc;
    m_ready = 1'b0;
    reset   = 1'b1;
    step_cycle();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) load(rand_word());
    for (int i = 0; i < 5; i++) step_cycle();
    m_ready = 1'b1;
    p0  = pops;
    cyc = 0;
    while ((pops - p0 < 5) && (cyc < 20)) begin
      step_cycle();
      cyc++;
    end
    checks++;
    if (stat_beats !== 32'd5) begin errors++; $display("FAIL stat_beats got %0d exp 5", stat_beats); end
    checks++;
    if (stat_stalls !== 32'd3) begin errors++; $display("FAIL stat_stalls got %0d exp 3", stat_stalls); end
  endtask
`endif

  initial begin
    reset      = 1'b1;
    m_ready    = 1'b0;
    fifo_empty = 1'b1;
    fifo_dout  = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_empty_bursts();
    test_reset_midflight();
    test_random();
`ifdef FIFO_STREAM_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_rd_stream_adapter.md
Name: fifo_rd_stream_adapter

Overview:
- Sits directly downstream of the BRAM-based prefetch FIFO, whose read data is registered: dout is valid one cycle after rd_en.
- Drives the FIFO's rd_en and captures its dout into a small register output buffer.
- Presents the data as a valid/ready stream to the prefetcher's response path.
- Sustains one beat per cycle, never reads an empty FIFO, never drops data under backpressure.

Parameters:
- Dw, 160, data width; must match the FIFO's Dw.
- OUT_DEPTH, 2, output buffer entries; minimum 2 for full throughput.
- CNTw, 32, statistics counter width; used only with FIFO_STREAM_STATS_EN.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset; shared with the upstream FIFO.
- fifo_dout  in  Dw  FIFO registered read data.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  FIFO read enable (combinational).
- m_valid  out  1  output beat valid.
- m_data  out  Dw  output beat data.
- m_ready  in  1  downstream accepts beat.
- stat_beats  out  CNTw  beats delivered; exists only with FIFO_STREAM_STATS_EN.
- stat_stalls  out  CNTw  cycles with m_valid & ~m_ready; exists only with FIFO_STREAM_STATS_EN.

Behaviour:
- State:
  - buffer buf[OUT_DEPTH] of Dw bits;
  - head/tail pointers, log2(OUT_DEPTH) bits each, wrapping at OUT_DEPTH-1 to 0 (OUT_DEPTH need not be a power of two);
  - count, log2(OUT_DEPTH+1) bits;
  - inflight, 1 bit.
- pop = m_valid & m_ready.
- fifo_rd_en = ~fifo_empty & ~reset & ((count + inflight - pop) < OUT_DEPTH). Evaluate at width log2(OUT_DEPTH+1)+1 so the subtraction cannot underflow.
- inflight <= fifo_rd_en each cycle. At most one read is ever outstanding, because the FIFO latency is 1.
- push = inflight. When inflight=1, fifo_dout is written to buf[tail] at the clock edge and tail advances.
- Pop: head advances, count decrements.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Overflow cannot occur because reservation counts inflight. Simulation check: $display + $finish if push with count==OUT_DEPTH and ~pop.
- m_valid = (count != 0). m_data = buf[head]. No bypass: m_data never comes combinationally from fifo_dout.
- Latency, with rd_en issued in cycle t:
  - fifo_dout valid in t+1, captured at the end of t+1;
  - m_valid high in t+2.
- Empty-to-first-beat latency is 2 cycles after fifo_empty deasserts.
- Steady state with m_ready=1: fifo_rd_en held high every cycle, m_valid high every cycle, no bubbles (count=1, inflight=1).
- m_ready=0: buffer fills to OUT_DEPTH, then fifo_rd_en drops. m_data is stable while m_valid & ~m_ready.
- Reset (synchronous, any cycle, including with a read in flight):
  - head, tail, count, inflight cleared to 0; stat counters cleared to 0;
  - fifo_rd_en forced to 0 during reset;
  - any in-flight datum is discarded, which is consistent because the FIFO resets in the same cycle;
  - reset values: m_valid=0, fifo_rd_en=0. m_data is unspecified while m_valid=0.
- fifo_empty is sampled only in the issue cycle. The FIFO guarantees data once rd_en is accepted.

Optional Feature:
- Macro: FIFO_STREAM_STATS_EN.
- With the macro defined:
  - stat_beats increments on every pop;
  - stat_stalls increments on every cycle with m_valid & ~m_ready;
  - both saturate at all-ones; both cleared by reset.
- Without the macro: the stat ports and counters do not exist. Datapath behaviour is identical either way.

Decomposition:
- Package fetchflare_fifo_pkg holds:
  - the shared log2 function;
  - default constants FETCH_DW=160 and OUT_DEPTH_DEF=2.
- Sub-module stream_out_buf holds the register buffer: head/tail/count with push/pop and full/empty.
- The adapter top contains only the read-issue reservation logic, the inflight flag, and the optional stats.

Test Plan:
- Basic beat: FIFO preloaded with 3 words (0xA, 0xB, 0xC), m_ready=1 throughout -> fifo_rd_en high cycles 0-2; m_valid high cycles 2-4; m_data 0xA, 0xB, 0xC in order; no bubbles.
- Backpressure: FIFO holds 8 words, m_ready=0 for 10 cycles -> exactly 2 reads issued, then fifo_rd_en=0; m_data stays at word0. Releasing m_ready yields all 8 in order, one per cycle after the first 2 buffered beats.
- Random ready: 1000 words, m_ready toggled at 50% -> output sequence equals input sequence; no FIFO empty-read or full-write error; fifo_rd_en never asserted while fifo_empty=1.
- Single word with empty bursts: FIFO alternately gets 1 word then is empty for 3 cycles -> each word appears 2 cycles after fifo_empty falls; m_valid is a 1-cycle pulse when m_ready=1.
- Reset mid-flight: assert reset in the cycle after fifo_rd_en=1 -> next cycle m_valid=0, count=0, inflight=0; after reset, a new word 0x55 is delivered alone with no stale data.
- Stats (FIFO_STREAM_STATS_EN defined): 5 beats delivered with 3 stall cycles -> stat_beats=5, stat_stalls=3. Build without the macro compiles with the stat ports absent.
